// File: rtl/bpu_pkg.sv
// ============================================================================
// Module : bpu_pkg
// Brief  : Shared types, constants and width helpers for the BPU table logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bpu_pkg;

  // 2-bit saturating branch counter
  typedef logic [1:0] ctr_t;

  // Weakly not-taken: one taken outcome flips the prediction
  localparam ctr_t CTR_INIT = 2'b01;

  // Table controller sequencing: sweep to defaults, then normal operation
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } tblc_state_t;

  localparam int TABLE_SIZE_DEF = 512;
  localparam int PC_SIZE_DEF    = 32;

  // Ceiling log2, usable in constant expressions
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of a table index
  function automatic int idx_w(input int table_size);
    return log2(table_size);
  endfunction

  // Alias tag covers the PC bits above the index and the word offset
  function automatic int tag_w(input int pc_size, input int table_size);
    return pc_size - log2(table_size) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_table_ctrl_ctr_next.sv
// ============================================================================
// Module : bpu_ctr_next
// Brief  : Combinational next state of a 2-bit saturating branch counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpu_ctr_next
  import bpu_pkg::*;
(
  input  ctr_t ctr_old,
  input  logic taken,
  output ctr_t ctr_new
);

  // Count toward the resolved outcome, saturating at 0 and 3
  always_comb begin
    ctr_new = ctr_old;
    if (taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpu_table_ctrl.sv
// ============================================================================
// Module : bpu_table_ctrl
// Brief  : Sweeps the branch-prediction tables to defaults after reset/flush,
//          then arbitrates the single table write port between counter
//          updates (branch resolve) and target updates (decode).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpu_table_ctrl
  import bpu_pkg::*;
#(
  parameter  int TABLE_SIZE = TABLE_SIZE_DEF,
  parameter  int PC_SIZE    = PC_SIZE_DEF,
  localparam int IDX_W      = idx_w(TABLE_SIZE),
  localparam int TAG_W      = tag_w(PC_SIZE, TABLE_SIZE)
)(
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush_req,
  input  logic               cnt_valid,
  output logic               cnt_ready,
  input  logic [IDX_W-1:0]   cnt_idx,
  input  logic [1:0]         cnt_old,
  input  logic               cnt_taken,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [IDX_W-1:0]   tgt_idx,
  input  logic [PC_SIZE-1:0] tgt_npc,
  input  logic [TAG_W-1:0]   tgt_tag,
  output logic [IDX_W-1:0]   tbl_idx,
  output logic               tbl_val_we,
  output logic               tbl_val,
  output logic               tbl_ctr_we,
  output logic [1:0]         tbl_ctr,
  output logic               tbl_npc_we,
  output logic [PC_SIZE-1:0] tbl_npc,
  output logic [TAG_W-1:0]   tbl_tag,
  output logic               lookup_en
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);

  tblc_state_t        state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic               starve_q, starve_d;
  logic               lookup_en_q, lookup_en_d;
  logic [IDX_W-1:0]   tbl_idx_q, tbl_idx_d;
  logic               tbl_val_we_q, tbl_val_we_d;
  logic               tbl_val_q, tbl_val_d;
  logic               tbl_ctr_we_q, tbl_ctr_we_d;
  ctr_t               tbl_ctr_q, tbl_ctr_d;
  logic               tbl_npc_we_q, tbl_npc_we_d;
  logic [PC_SIZE-1:0] tbl_npc_q, tbl_npc_d;
  logic [TAG_W-1:0]   tbl_tag_q, tbl_tag_d;
  ctr_t               ctr_upd;

  bpu_ctr_next u_ctr_next (
    .ctr_old (cnt_old),
    .taken   (cnt_taken),
    .ctr_new (ctr_upd)
  );

  // State, sweep pointer, arbitration history and registered table outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= INIT;
      sweep_idx_q  <= '0;
      starve_q     <= 1'b0;
      lookup_en_q  <= 1'b0;
      tbl_idx_q    <= '0;
      tbl_val_we_q <= 1'b0;
      tbl_val_q    <= 1'b0;
      tbl_ctr_we_q <= 1'b0;
      tbl_ctr_q    <= '0;
      tbl_npc_we_q <= 1'b0;
      tbl_npc_q    <= '0;
      tbl_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      starve_q     <= starve_d;
      lookup_en_q  <= lookup_en_d;
      tbl_idx_q    <= tbl_idx_d;
      tbl_val_we_q <= tbl_val_we_d;
      tbl_val_q    <= tbl_val_d;
      tbl_ctr_we_q <= tbl_ctr_we_d;
      tbl_ctr_q    <= tbl_ctr_d;
      tbl_npc_we_q <= tbl_npc_we_d;
      tbl_npc_q    <= tbl_npc_d;
      tbl_tag_q    <= tbl_tag_d;
    end
  end

  // Next state: sweep every entry once, flush restarts the sweep
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      INIT: begin
        if (flush_req) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          state_d     = RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      RUN: begin
        if (flush_req) begin
          state_d     = INIT;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  // Outputs: sweep writes, or arbitrated request acceptance and the write it produces
  always_comb begin
    cnt_ready    = 1'b0;
    tgt_ready    = 1'b0;
    starve_d     = 1'b0;
    tbl_idx_d    = tbl_idx_q;
    tbl_val_we_d = 1'b0;
    tbl_val_d    = tbl_val_q;
    tbl_ctr_we_d = 1'b0;
    tbl_ctr_d    = tbl_ctr_q;
    tbl_npc_we_d = 1'b0;
    tbl_npc_d    = tbl_npc_q;
    tbl_tag_d    = tbl_tag_q;
    lookup_en_d  = (state_d == RUN);
    if (state_q == INIT) begin
      tbl_idx_d    = sweep_idx_q;
      tbl_val_we_d = 1'b1;
      tbl_val_d    = 1'b0;
      tbl_ctr_we_d = 1'b1;
      tbl_ctr_d    = CTR_INIT;
      tbl_npc_we_d = 1'b1;
      tbl_npc_d    = '0;
      tbl_tag_d    = '0;
    end else if (!flush_req) begin
      // Conflicting indices: target wins unless the counter already waited a cycle
      if (cnt_valid && tgt_valid && (cnt_idx != tgt_idx)) begin
        cnt_ready = starve_q;
        tgt_ready = !starve_q;
      end else begin
        cnt_ready = cnt_valid;
        tgt_ready = tgt_valid;
      end
      starve_d = cnt_valid && !cnt_ready;
      if (tgt_ready) begin
        tbl_idx_d    = tgt_idx;
        tbl_val_we_d = 1'b1;
        tbl_val_d    = 1'b1;
        tbl_npc_we_d = 1'b1;
        tbl_npc_d    = tgt_npc;
        tbl_tag_d    = tgt_tag;
      end
      if (cnt_ready) begin
        tbl_idx_d    = cnt_idx;
        tbl_ctr_we_d = 1'b1;
        tbl_ctr_d    = ctr_upd;
      end
    end
  end

  assign tbl_idx    = tbl_idx_q;
  assign tbl_val_we = tbl_val_we_q;
  assign tbl_val    = tbl_val_q;
  assign tbl_ctr_we = tbl_ctr_we_q;
  assign tbl_ctr    = tbl_ctr_q;
  assign tbl_npc_we = tbl_npc_we_q;
  assign tbl_npc    = tbl_npc_q;
  assign tbl_tag    = tbl_tag_q;
  assign lookup_en  = lookup_en_q;

endmodule

`default_nettype wire

// File: tb/tb_bpu_table_ctrl.sv
// ============================================================================
// Module : tb_bpu_table_ctrl
// Brief  : Self-checking bench for bpu_table_ctrl (vectors, sequences, random).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bpu_table_ctrl;
  import bpu_pkg::*;

  localparam int TS = 512;
  localparam int PW = 32;
  localparam int IW = 9;
  localparam int TW = 21;

  logic          clk, nrst, flush_req;
  logic          cnt_valid, cnt_ready, cnt_taken;
  logic [IW-1:0] cnt_idx;
  logic [1:0]    cnt_old;
  logic          tgt_valid, tgt_ready;
  logic [IW-1:0] tgt_idx;
  logic [PW-1:0] tgt_npc;
  logic [TW-1:0] tgt_tag;
  logic [IW-1:0] tbl_idx;
  logic          tbl_val_we, tbl_val, tbl_ctr_we, tbl_npc_we, lookup_en;
  logic [1:0]    tbl_ctr;
  logic [PW-1:0] tbl_npc;
  logic [TW-1:0] tbl_tag;

  bpu_table_ctrl #(.TABLE_SIZE(TS), .PC_SIZE(PW)) dut (
    .clk(clk), .nrst(nrst), .flush_req(flush_req),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_idx(cnt_idx),
    .cnt_old(cnt_old), .cnt_taken(cnt_taken),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_idx(tgt_idx),
    .tgt_npc(tgt_npc), .tgt_tag(tgt_tag),
    .tbl_idx(tbl_idx), .tbl_val_we(tbl_val_we), .tbl_val(tbl_val),
    .tbl_ctr_we(tbl_ctr_we), .tbl_ctr(tbl_ctr), .tbl_npc_we(tbl_npc_we),
    .tbl_npc(tbl_npc), .tbl_tag(tbl_tag), .lookup_en(lookup_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int old, input bit taken);
    if (taken) return (old >= 3) ? 3 : old + 1;
    return (old <= 0) ? 0 : old - 1;
  endfunction

  task automatic idle_inputs();
    flush_req = 1'b0; cnt_valid = 1'b0; tgt_valid = 1'b0;
    cnt_idx = '0; cnt_old = '0; cnt_taken = 1'b0;
    tgt_idx = '0; tgt_npc = '0; tgt_tag = '0;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " ctl"}, 64'({tbl_val_we, tbl_ctr_we, tbl_npc_we, tbl_val, tbl_ctr,
                          tbl_idx, lookup_en, cnt_ready, tgt_ready}), 64'd0);
    chk({nm, " npc"}, 64'(tbl_npc), 64'd0);
    chk({nm, " tag"}, 64'(tbl_tag), 64'd0);
  endtask

  // Expects the next posedge to produce the write of entry 0
  task automatic sweep_check(input string nm);
    int n;
    int first_lk;
    bit ok;
    n = 0; first_lk = -1; ok = 1'b1;
    for (int c = 1; c <= 600 && first_lk < 0; c++) begin
      @(posedge clk); #1;
      if (tbl_val_we) begin
        if (tbl_idx !== IW'(n) || tbl_ctr !== 2'b01 || tbl_val !== 1'b0 ||
            tbl_ctr_we !== 1'b1 || tbl_npc_we !== 1'b1 || tbl_npc !== '0 ||
            tbl_tag !== '0) ok = 1'b0;
        n++;
      end
      if (cnt_ready !== 1'b0 || tgt_ready !== 1'b0) ok = 1'b0;
      if (lookup_en === 1'b1) first_lk = c;
    end
    chk({nm, " write count"}, 64'(n), 64'd512);
    chk({nm, " write content"}, 64'(ok), 64'd1);
    chk({nm, " lookup_en edge"}, 64'(first_lk), 64'd512);
  endtask

  typedef struct {
    logic          cv; logic [IW-1:0] ci; logic [1:0] co; logic ct;
    logic          tv; logic [IW-1:0] ti; logic [PW-1:0] tn; logic [TW-1:0] tt;
    logic          ecr, etr, evwe, ecwe, enwe;
    logic [IW-1:0] eidx; logic [1:0] ectr;
  } vec_t;

  vec_t vecs[7];

  // Random-phase reference state
  int          m_idx, m_val, m_ctr;
  logic [PW-1:0] m_npc;
  logic [TW-1:0] m_tag;
  bit          waited, ea_c, ea_t, c_acc, t_acc, found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 9'd3,  2'd3, 1'b1, 1'b0, 9'd0,  32'h0,         21'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd3,  2'd3};
    vecs[1] = '{1'b1, 9'd4,  2'd0, 1'b0, 1'b0, 9'd0,  32'h0,         21'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd4,  2'd0};
    vecs[2] = '{1'b1, 9'd6,  2'd1, 1'b1, 1'b0, 9'd0,  32'h0,         21'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd6,  2'd2};
    vecs[3] = '{1'b1, 9'd10, 2'd2, 1'b0, 1'b0, 9'd0,  32'h0,         21'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd10, 2'd1};
    vecs[4] = '{1'b0, 9'd0,  2'd0, 1'b0, 1'b1, 9'd12, 32'h1234_5678, 21'h0abcd,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd12, 2'd0};
    vecs[5] = '{1'b1, 9'd5,  2'd2, 1'b1, 1'b1, 9'd5,  32'hdead_beef, 21'h1f00f,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9'd5,  2'd3};
    vecs[6] = '{1'b1, 9'd20, 2'd1, 1'b1, 1'b1, 9'd21, 32'h0000_4444, 21'h00123,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd21, 2'd0};

    idle_inputs();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk); nrst = 1'b1;
    sweep_check("reset sweep");

    // Table-driven single requests / pairs, each followed by an idle cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cnt_valid = vecs[i].cv; cnt_idx = vecs[i].ci; cnt_old = vecs[i].co;
      cnt_taken = vecs[i].ct; tgt_valid = vecs[i].tv; tgt_idx = vecs[i].ti;
      tgt_npc = vecs[i].tn; tgt_tag = vecs[i].tt;
      #1;
      chk($sformatf("vec%0d cnt_ready", i), 64'(cnt_ready), 64'(vecs[i].ecr));
      chk($sformatf("vec%0d tgt_ready", i), 64'(tgt_ready), 64'(vecs[i].etr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d we", i), 64'({tbl_val_we, tbl_ctr_we, tbl_npc_we}),
          64'({vecs[i].evwe, vecs[i].ecwe, vecs[i].enwe}));
      chk($sformatf("vec%0d idx", i), 64'(tbl_idx), 64'(vecs[i].eidx));
      if (vecs[i].ecwe) chk($sformatf("vec%0d ctr", i), 64'(tbl_ctr), 64'(vecs[i].ectr));
      if (vecs[i].evwe) begin
        chk($sformatf("vec%0d val/npc/tag", i), {31'd0, tbl_val, tbl_npc},
            {31'd0, 1'b1, vecs[i].tn});
        chk($sformatf("vec%0d tag", i), 64'(tbl_tag), 64'(vecs[i].tt));
      end
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      chk($sformatf("vec%0d idle we", i), 64'({tbl_val_we, tbl_ctr_we, tbl_npc_we}), 64'd0);
    end

    // Counter held against a streaming target to other entries
    @(negedge clk);
    cnt_valid = 1'b1; cnt_idx = 9'd9; cnt_old = 2'd1; cnt_taken = 1'b0;
    tgt_valid = 1'b1; tgt_idx = 9'd7; tgt_npc = 32'h0000_0070; tgt_tag = 21'h7;
    #1;
    chk("starve c1 readies", 64'({cnt_ready, tgt_ready}), 64'b01);
    @(posedge clk); #1;
    chk("starve c1 write", 64'({tbl_val_we, tbl_ctr_we, tbl_idx}), 64'({2'b10, 9'd7}));
    @(negedge clk);
    tgt_idx = 9'd8; tgt_npc = 32'h0000_0080; tgt_tag = 21'h8;
    #1;
    chk("starve c2 readies", 64'({cnt_ready, tgt_ready}), 64'b10);
    @(posedge clk); #1;
    chk("starve c2 write", 64'({tbl_val_we, tbl_ctr_we, tbl_ctr, tbl_idx}),
        64'({2'b01, 2'd0, 9'd9}));
    @(negedge clk);
    cnt_valid = 1'b0;
    #1;
    chk("starve c3 tgt_ready", 64'(tgt_ready), 64'd1);
    @(posedge clk); #1;
    chk("starve c3 write", 64'({tbl_val_we, tbl_ctr_we, tbl_idx}), 64'({2'b10, 9'd8}));
    chk("starve c3 npc", 64'(tbl_npc), 64'h80);

    // Flush while a target update is offered
    @(negedge clk);
    idle_inputs();
    flush_req = 1'b1; tgt_valid = 1'b1; tgt_idx = 9'd3; tgt_npc = 32'h33;
    #1;
    chk("flush tgt_ready", 64'(tgt_ready), 64'd0);
    @(posedge clk); #1;
    chk("flush lookup_en", 64'(lookup_en), 64'd0);
    chk("flush no write", 64'({tbl_val_we, tbl_ctr_we, tbl_npc_we}), 64'd0);
    @(negedge clk); idle_inputs();
    sweep_check("flush sweep");

    // Random traffic against the reference model; data starts at the sweep defaults
    m_idx = TS - 1; m_val = 0; m_ctr = 1; m_npc = '0; m_tag = '0;
    waited = 1'b0; c_acc = 1'b0; t_acc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!cnt_valid || c_acc) begin
        cnt_valid = ($urandom_range(0, 9) < 6);
        cnt_idx = IW'($urandom_range(0, 3));
        cnt_old = 2'($urandom);
        cnt_taken = 1'($urandom);
      end
      if (!tgt_valid || t_acc) begin
        tgt_valid = ($urandom_range(0, 9) < 6);
        tgt_idx = IW'($urandom_range(0, 3));
        tgt_npc = $urandom;
        tgt_tag = TW'($urandom);
      end
      if (cnt_valid && tgt_valid && cnt_idx != tgt_idx) begin
        ea_c = waited; ea_t = !waited;
      end else begin
        ea_c = cnt_valid; ea_t = tgt_valid;
      end
      waited = cnt_valid && !ea_c;
      if (ea_t) begin m_idx = int'(tgt_idx); m_val = 1; m_npc = tgt_npc; m_tag = tgt_tag; end
      if (ea_c) begin m_idx = int'(cnt_idx); m_ctr = sat(int'(cnt_old), cnt_taken); end
      c_acc = ea_c; t_acc = ea_t;
      #1;
      chk($sformatf("rnd%0d readies", n), 64'({cnt_ready, tgt_ready}), 64'({ea_c, ea_t}));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d we", n), 64'({tbl_val_we, tbl_ctr_we, tbl_npc_we}),
          64'({ea_t, ea_c, ea_t}));
      chk($sformatf("rnd%0d idx/val/ctr", n), 64'({tbl_idx, tbl_val, tbl_ctr}),
          64'({IW'(m_idx), 1'(m_val), 2'(m_ctr)}));
      chk($sformatf("rnd%0d npc/tag", n), {11'd0, tbl_tag, tbl_npc}, {11'd0, m_tag, m_npc});
    end

    // Asynchronous reset in the middle of a sweep
    @(negedge clk); idle_inputs(); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clk); #1;
      if (tbl_val_we === 1'b1 && tbl_idx === 9'd99) found = 1'b1;
    end
    chk("midsweep reached idx 99", 64'(found), 64'd1);
    nrst = 1'b0;
    #1;
    check_reset("async reset");
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    sweep_check("post-reset sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
